// File: rtl/sat_arith_pkg.sv
// Width-generic saturating arithmetic shared by the adder tree and its stages.
// Values travel in a 64-bit carrier; only the low w bits are meaningful (w <= 64).
package sat_arith_pkg;

    localparam int SAT_MAX_W = 64;

    typedef logic [SAT_MAX_W-1:0] sat_word_t;

    function automatic sat_word_t sat_mask(input int w);
        sat_word_t m;
        m = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            m[i] = (i < w);
        end
        return m;
    endfunction

    function automatic sat_word_t sat_max(input int w);
        return sat_mask(w - 1);
    endfunction

    function automatic sat_word_t sat_min(input int w);
        return sat_mask(w) & ~sat_mask(w - 1);
    endfunction

    function automatic logic sat_sign(input sat_word_t x, input int w);
        return |(x & sat_min(w));
    endfunction

    // Overflow is judged from operand signs against the sign of the wrapped sum.
    function automatic logic sat_add_ovf(input sat_word_t a, input sat_word_t b, input int w);
        sat_word_t raw;
        logic      sa;
        logic      sb;
        logic      sr;
        raw = (a + b) & sat_mask(w);
        sa  = sat_sign(a, w);
        sb  = sat_sign(b, w);
        sr  = sat_sign(raw, w);
        return (sa && sb && !sr) || (!sa && !sb && sr);
    endfunction

    function automatic sat_word_t sat_add_sum(input sat_word_t a, input sat_word_t b, input int w);
        sat_word_t raw;
        logic      sa;
        logic      sb;
        logic      sr;
        raw = (a + b) & sat_mask(w);
        sa  = sat_sign(a, w);
        sb  = sat_sign(b, w);
        sr  = sat_sign(raw, w);
        if (sa && sb && !sr) begin
            return sat_min(w);
        end
        if (!sa && !sb && sr) begin
            return sat_max(w);
        end
        return raw;
    endfunction

endpackage

// File: rtl/sat_adder_tree_if.sv
// Beat input and result output bundle of the saturating adder tree.
interface sat_adder_tree_if #(
    parameter int N_IN   = 8,
    parameter int DATA_W = 28
);
    logic                     in_valid;
    logic [N_IN*DATA_W-1:0]   in_data;
    logic                     in_last;
    logic                     acc_mode;
    logic                     sat_clear;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_sat;
    logic                     sat_sticky;

    modport master (
        output in_valid, in_data, in_last, acc_mode, sat_clear,
        input  out_valid, out_data, out_sat, sat_sticky
    );

    modport slave (
        input  in_valid, in_data, in_last, acc_mode, sat_clear,
        output out_valid, out_data, out_sat, sat_sticky
    );
endinterface

// File: rtl/sat_add_stage.sv
// One registered tree node: saturating add of two children, carrying valid,
// saturation flag and beat sideband forward one cycle.
module sat_add_stage
    import sat_arith_pkg::*;
#(
    parameter int DATA_W = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_sat,
    input  logic              b_sat,
    input  logic              in_last,
    input  logic              in_acc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              out_last,
    output logic              out_acc
);

    logic [DATA_W-1:0] sum;
    logic              ovf;

    always_comb begin
        sum = DATA_W'(sat_add_sum(sat_word_t'(a), sat_word_t'(b), DATA_W));
        ovf = sat_add_ovf(sat_word_t'(a), sat_word_t'(b), DATA_W);
    end

    // Payload only loads on valid beats; bubbles just drop the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_last  <= 1'b0;
            out_acc   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= sum;
                out_sat  <= a_sat | b_sat | ovf;
                out_last <= in_last;
                out_acc  <= in_acc;
            end
        end
    end

endmodule

// File: rtl/sat_adder_tree.sv
// Pipelined saturating adder tree (log2(N_IN) levels) followed by an output
// stage that either passes the tree sum or accumulates it over a beat group.
module sat_adder_tree
    import sat_arith_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int DATA_W = 28
) (
    input  logic            clk,
    input  logic            reset,
    sat_adder_tree_if.slave bus
);

    localparam int NODES = 2 * N_IN;

    // Heap numbering: node 1 is the root, node i has children 2i and 2i+1,
    // and operand k sits at leaf N_IN+k, so siblings are adjacent operands.
    logic [DATA_W-1:0] node_data  [1:NODES-1];
    logic              node_valid [1:NODES-1];
    logic              node_sat   [1:NODES-1];
    logic              node_last  [1:NODES-1];
    logic              node_acc   [1:NODES-1];

    for (genvar k = 0; k < N_IN; k++) begin : g_leaf
        assign node_data[N_IN+k]  = bus.in_data[k*DATA_W +: DATA_W];
        assign node_valid[N_IN+k] = bus.in_valid;
        assign node_sat[N_IN+k]   = 1'b0;
        assign node_last[N_IN+k]  = bus.in_last;
        assign node_acc[N_IN+k]   = bus.acc_mode;
    end

    // Sibling sidebands always match, so combining them is lossless.
    for (genvar i = 1; i < N_IN; i++) begin : g_node
        sat_add_stage #(.DATA_W(DATA_W)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (node_valid[2*i] & node_valid[2*i+1]),
            .a         (node_data[2*i]),
            .b         (node_data[2*i+1]),
            .a_sat     (node_sat[2*i]),
            .b_sat     (node_sat[2*i+1]),
            .in_last   (node_last[2*i] & node_last[2*i+1]),
            .in_acc    (node_acc[2*i] & node_acc[2*i+1]),
            .out_valid (node_valid[i]),
            .out_data  (node_data[i]),
            .out_sat   (node_sat[i]),
            .out_last  (node_last[i]),
            .out_acc   (node_acc[i])
        );
    end

    logic [DATA_W-1:0] acc_data;
    logic              acc_sat;
    logic [DATA_W-1:0] acc_sum;
    logic              acc_sat_sum;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sat_q;
    logic              sticky_q;

    always_comb begin
        acc_sum     = DATA_W'(sat_add_sum(sat_word_t'(acc_data), sat_word_t'(node_data[1]), DATA_W));
        acc_sat_sum = acc_sat | node_sat[1]
                    | sat_add_ovf(sat_word_t'(acc_data), sat_word_t'(node_data[1]), DATA_W);
    end

    // Pass-through beats never touch the accumulator, so a group may be
    // interleaved with them; a closing beat emits and re-arms the group.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_data    <= '0;
            acc_sat     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (node_valid[1]) begin
                if (!node_acc[1]) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= node_data[1];
                    out_sat_q   <= node_sat[1];
                end else if (node_last[1]) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_sum;
                    out_sat_q   <= acc_sat_sum;
                    acc_data    <= '0;
                    acc_sat     <= 1'b0;
                end else begin
                    acc_data    <= acc_sum;
                    acc_sat     <= acc_sat_sum;
                end
            end
            if (out_valid_q && out_sat_q) begin
                sticky_q <= 1'b1;
            end else if (bus.sat_clear) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sat    = out_sat_q;
    assign bus.sat_sticky = sticky_q;

endmodule

// File: doc/sat_adder_tree.md
SAT_ADDER_TREE -- requirements
Module: sat_adder_tree

Interface
REQ-001 SHALL have parameter N_IN, default 8, number of signed input operands; power of two, 2..64.
REQ-002 SHALL have parameter DATA_W, default 28, width of every operand, intermediate sum and result.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_data/in_last/acc_mode valid this cycle.
REQ-006 SHALL have port in_data  input  N_IN*DATA_W  packed signed operands; operand k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port in_last  input  1  final beat of an accumulation group; ignored when acc_mode=0.
REQ-008 SHALL have port acc_mode  input  1  0 = pass tree sum, 1 = accumulate tree sums across beats.
REQ-009 SHALL have port sat_clear  input  1  clears sat_sticky.
REQ-010 SHALL have port out_valid  output  1  single-cycle pulse, out_data valid.
REQ-011 SHALL have port out_data  output  DATA_W  signed result; held between pulses.
REQ-012 SHALL have port out_sat  output  1  a saturation occurred anywhere in producing out_data; qualified by out_valid.
REQ-013 SHALL have port sat_sticky  output  1  set by any out_valid with out_sat=1; held until cleared.

Function
REQ-014 SHALL reduce N_IN operands by a binary tree of L = log2(N_IN) levels, one register per level, pairing adjacent operands (2k, 2k+1).
REQ-015 SHALL compute every addition as DATA_W-bit signed saturating: both operands negative and raw sum non-negative -> MIN (MSB 1, rest 0); both non-negative and raw sum negative -> MAX (MSB 0, rest 1); otherwise wrap-free raw sum.
REQ-016 SHALL carry a valid bit, sat flag, in_last and acc_mode alongside each level's data; sat flag at a node = OR of child flags and own saturation.
REQ-017 SHALL add a final output stage, so in_valid to out_valid latency is exactly L+1 cycles.
REQ-018 SHALL accept a new beat every cycle (no backpressure); bubbles in in_valid appear as identical bubbles in out_valid; result order preserved.
REQ-019 SHALL, for a beat with acc_mode=0, set out_data = tree sum, out_sat = tree flag, pulse out_valid; accumulator unaffected.
REQ-020 SHALL, for a beat with acc_mode=1, update accumulator = sat_add(accumulator, tree sum), OR flags into accumulator flag, and pulse out_valid only if in_last=1.
REQ-021 SHALL, on an acc_mode=1 in_last=1 beat, output the updated accumulator and its flag, then clear accumulator and flag to 0 for the next group.
REQ-022 SHALL treat acc_mode=0 beats arriving mid-group as pass-through, leaving the open group's accumulator intact.
REQ-023 SHALL not register invalid beats: stage data may hold, valid bits are 0, accumulator unchanged.
REQ-024 SHALL set sat_sticky when sat_clear and a saturating out_valid coincide (set wins).

Reset
REQ-025 SHALL, on reset, clear all stage valid bits, data, flags, accumulator, out_valid, out_data, out_sat and sat_sticky to 0 on the next posedge.
REQ-026 SHALL discard all in-flight beats and any open accumulation group on reset; no out_valid in the L+1 cycles after reset deasserts unless new beats are applied.

Structure
REQ-027 SHALL place a saturating-add function and MAX/MIN constant generators (parametrised by width) in shared package sat_arith_pkg.
REQ-028 SHALL use one sub-module sat_add_stage: registered saturating adder with valid/flag/sideband pass-through, instantiated per node via generate.

Verification (N_IN=8, DATA_W=28, L+1=4)
REQ-029 SHALL cover: operands 1..8, acc_mode=0 -> out_data=36, out_sat=0, out_valid exactly 4 cycles after in_valid.
REQ-030 SHALL cover: all operands 0x7FFFFFF -> out_data=0x7FFFFFF, out_sat=1, sat_sticky=1; all 0x8000000 -> 0x8000000, out_sat=1.
REQ-031 SHALL cover: 5 back-to-back beats, bubble, 2 beats -> 5 pulses, one-cycle gap, 2 pulses, values in order.
REQ-032 SHALL cover: 3 beats of all-ones operands acc_mode=1, in_last on third -> single pulse out_data=24; following group restarts from 0.
REQ-033 SHALL cover: reset asserted with 3 beats in flight and open group -> no out_valid afterwards, all outputs 0.
REQ-034 SHALL cover: sat_clear pulsed with saturating out_valid same cycle -> sat_sticky stays 1; sat_clear alone -> 0.
